instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch.sv | 159 +++++++++++++++
 tb/tb_instruction_fetch.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage sitting directly in front of the instruction memory. Owns the
//   program counter, presents it as the fetch byte address, and captures the
//   combinationally returned word into the IF/ID register for decode. Handles
//   stall, flush and branch/jump redirect. A misaligned or out-of-range fetch
//   halts the stage with a sticky fault until reset.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   imem_addr       byte address to instruction memory (always the PC)
//   imem_instr      instruction word returned for imem_addr
//   stall           hold PC and IF/ID contents
//   flush           invalidate IF/ID contents
//   redirect_valid  taken branch/jump, load redirect_pc
//   redirect_pc     redirect target byte address
//   if_id_valid     IF/ID holds a live instruction
//   if_id_instr     captured instruction
//   if_id_pc        address of captured instruction
//   if_id_pc_plus4  if_id_pc + 4
//   fetch_fault     sticky fault flag
//   fault_pc        offending address latched on fault
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int                   WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
  parameter int                   MEM_BYTES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [WORD_SIZE-1:0] imem_addr,
  input  logic [WORD_SIZE-1:0] imem_instr,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 if_id_valid,
  output logic [WORD_SIZE-1:0] if_id_instr,
  output logic [WORD_SIZE-1:0] if_id_pc,
  output logic [WORD_SIZE-1:0] if_id_pc_plus4,
  output logic                 fetch_fault,
  output logic [WORD_SIZE-1:0] fault_pc
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [WORD_SIZE:0] LAST_BYTE = (WORD_SIZE+1)'(MEM_BYTES - 1);

  // One extra bit so that an address near 2^WORD_SIZE does not wrap back
  // into the legal window when the last byte of the word is computed.
  function automatic logic out_of_range(input logic [WORD_SIZE-1:0] addr);
    logic [WORD_SIZE:0] last;
    last = {1'b0, addr} + (WORD_SIZE+1)'(3);
    return last > LAST_BYTE;
  endfunction

  function automatic logic misaligned(input logic [WORD_SIZE-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  logic [1:0]           state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic                 valid_q, valid_d;
  logic [WORD_SIZE-1:0] instr_q, instr_d;
  logic [WORD_SIZE-1:0] ipc_q, ipc_d;
  logic [WORD_SIZE-1:0] ipc4_q, ipc4_d;
  logic                 fault_q, fault_d;
  logic [WORD_SIZE-1:0] fpc_q, fpc_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    fault_d = fault_q;
    fpc_d   = fpc_q;

    case (state_q)
      S_BOOT: begin
        // Settling cycle: the memory sees RESET_PC before the first capture.
        state_d = S_RUN;
        valid_d = 1'b0;
      end

      S_RUN: begin
        if (redirect_valid) begin
          // The instruction in IF/ID is on the wrong path either way.
          valid_d = 1'b0;
          if (misaligned(redirect_pc) || out_of_range(redirect_pc)) begin
            state_d = S_HALT;
            fault_d = 1'b1;
            fpc_d   = redirect_pc;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (stall) begin
          if (flush) valid_d = 1'b0;
        end else if (out_of_range(pc_q)) begin
          state_d = S_HALT;
          fault_d = 1'b1;
          fpc_d   = pc_q;
          valid_d = 1'b0;
        end else begin
          // Capture happens even under flush; only the valid bit is dropped.
          instr_d = imem_instr;
          ipc_d   = pc_q;
          ipc4_d  = pc_q + WORD_SIZE'(4);
          pc_d    = pc_q + WORD_SIZE'(4);
          valid_d = ~flush;
        end
      end

      S_HALT: begin
        valid_d = 1'b0;
      end

      default: begin
        state_d = S_BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      ipc4_q  <= '0;
      fault_q <= 1'b0;
      fpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      fault_q <= fault_d;
      fpc_q   <= fpc_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_valid    = valid_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc       = ipc_q;
  assign if_id_pc_plus4 = ipc4_q;
  assign fetch_fault    = fault_q;
  assign fault_pc       = fpc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Drives two fetch stages (1024-byte and 16-byte instruction memories) with
//   the same stimulus and checks both against a behavioural model every cycle,
//   plus literal expectations at directed points.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst, stall, flush, rv;
  logic [31:0] rpc;

  logic [31:0] a_addr, a_instr_in, a_instr, a_ipc, a_ipc4, a_fpc;
  logic        a_valid, a_fault;
  logic [31:0] b_addr, b_instr_in, b_instr, b_ipc, b_ipc4, b_fpc;
  logic        b_valid, b_fault;

  logic [31:0] mem [256];

  int n_chk  = 0;
  int n_fail = 0;
  bit run_cmp = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a < 32'd1024) return mem[a[9:2]];
    return a ^ 32'hA5A5_0000;
  endfunction

  assign a_instr_in = memw(a_addr);
  assign b_instr_in = memw(b_addr);

  instruction_fetch #(.WORD_SIZE(32), .RESET_PC(32'h0), .MEM_BYTES(1024)) dut_a (
    .clk(clk), .rst(rst), .imem_addr(a_addr), .imem_instr(a_instr_in),
    .stall(stall), .flush(flush), .redirect_valid(rv), .redirect_pc(rpc),
    .if_id_valid(a_valid), .if_id_instr(a_instr), .if_id_pc(a_ipc),
    .if_id_pc_plus4(a_ipc4), .fetch_fault(a_fault), .fault_pc(a_fpc)
  );

  instruction_fetch #(.WORD_SIZE(32), .RESET_PC(32'h0), .MEM_BYTES(16)) dut_b (
    .clk(clk), .rst(rst), .imem_addr(b_addr), .imem_instr(b_instr_in),
    .stall(stall), .flush(flush), .redirect_valid(rv), .redirect_pc(rpc),
    .if_id_valid(b_valid), .if_id_instr(b_instr), .if_id_pc(b_ipc),
    .if_id_pc_plus4(b_ipc4), .fetch_fault(b_fault), .fault_pc(b_fpc)
  );

  // ---------------- behavioural model ----------------
  // ph: 0 = settling after reset, 1 = fetching, 2 = halted
  typedef struct {
    int          ph;
    logic [31:0] pc, instr, ipc, ipc4, fpc;
    bit          valid, fault;
  } mdl_t;

  mdl_t ma, mb;

  function automatic bit illegal(input logic [31:0] a, input longint mbytes);
    return (a % 4 != 0) || (longint'(a) + 3 > mbytes - 1);
  endfunction

  function automatic mdl_t step(input mdl_t m, input bit r, input bit st, input bit fl,
                                input bit rdv, input logic [31:0] rdpc, input longint mbytes);
    mdl_t n = m;
    if (r) begin
      n.ph = 0; n.pc = 0; n.valid = 0; n.instr = 0; n.ipc = 0; n.ipc4 = 0;
      n.fault = 0; n.fpc = 0;
    end else if (m.ph == 0) begin
      n.ph = 1;
    end else if (m.ph == 1) begin
      if (rdv) begin
        n.valid = 0;
        if (illegal(rdpc, mbytes)) begin
          n.ph = 2; n.fault = 1; n.fpc = rdpc;
        end else n.pc = rdpc;
      end else if (st) begin
        if (fl) n.valid = 0;
      end else if (illegal(m.pc, mbytes)) begin
        n.ph = 2; n.fault = 1; n.fpc = m.pc; n.valid = 0;
      end else begin
        n.instr = memw(m.pc);
        n.ipc   = m.pc;
        n.ipc4  = m.pc + 32'd4;
        n.pc    = m.pc + 32'd4;
        n.valid = !fl;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    ma = step(ma, rst, stall, flush, rv, rpc, 1024);
    mb = step(mb, rst, stall, flush, rv, rpc, 16);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("a.imem_addr", a_addr, ma.pc);
      chk("a.valid", 32'(a_valid), 32'(ma.valid));
      chk("a.instr", a_instr, ma.instr);
      chk("a.pc", a_ipc, ma.ipc);
      chk("a.pc_plus4", a_ipc4, ma.ipc4);
      chk("a.fault", 32'(a_fault), 32'(ma.fault));
      chk("a.fault_pc", a_fpc, ma.fpc);
      chk("b.imem_addr", b_addr, mb.pc);
      chk("b.valid", 32'(b_valid), 32'(mb.valid));
      chk("b.instr", b_instr, mb.instr);
      chk("b.pc", b_ipc, mb.ipc);
      chk("b.pc_plus4", b_ipc4, mb.ipc4);
      chk("b.fault", 32'(b_fault), 32'(mb.fault));
      chk("b.fault_pc", b_fpc, mb.fpc);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; rv = 1'b0; rpc = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;

    cyc(); cyc();
    run_cmp = 1'b1;
    chk("rst_addr", a_addr, 32'h0);
    chk("rst_valid", 32'(a_valid), 32'h0);
    chk("rst_fault", 32'(a_fault), 32'h0);
    chk("rst_instr", a_instr, 32'h0);

    // Free run from reset: settling cycle, then captures at 0 and 4.
    rst = 1'b0;
    cyc();
    chk("boot_valid", 32'(a_valid), 32'h0);
    chk("boot_addr", a_addr, 32'h0);
    cyc();
    chk("cap0_valid", 32'(a_valid), 32'h1);
    chk("cap0_pc", a_ipc, 32'h0);
    chk("cap0_instr", a_instr, 32'h2008_0005);
    cyc();
    chk("cap4_pc", a_ipc, 32'h4);
    chk("cap4_instr", a_instr, 32'h2009_0003);
    chk("cap4_plus4", a_ipc4, 32'h8);
    cyc(); cyc();
    chk("small_cap12_pc", b_ipc, 32'd12);
    chk("small_cap12_valid", 32'(b_valid), 32'h1);
    chk("small_addr16", b_addr, 32'd16);
    cyc();
    chk("small_fault", 32'(b_fault), 32'h1);
    chk("small_fault_pc", b_fpc, 32'd16);
    chk("small_nocap_valid", 32'(b_valid), 32'h0);
    chk("small_nocap_pc", b_ipc, 32'd12);

    // Stall, redirect-under-stall, flush and misaligned redirect.
    rst = 1'b1; cyc(); rst = 1'b0;
    cyc(); cyc(); cyc();
    chk("pre_stall_pc", a_ipc, 32'h4);
    stall = 1'b1;
    repeat (3) cyc();
    chk("stall_addr", a_addr, 32'h8);
    chk("stall_pc", a_ipc, 32'h4);
    chk("stall_instr", a_instr, 32'h2009_0003);
    chk("stall_valid", 32'(a_valid), 32'h1);
    stall = 1'b0;
    cyc();
    chk("post_stall_pc", a_ipc, 32'h8);
    stall = 1'b1; rv = 1'b1; rpc = 32'h40;
    cyc();
    chk("redir_valid", 32'(a_valid), 32'h0);
    chk("redir_addr", a_addr, 32'h40);
    stall = 1'b0; rv = 1'b0;
    cyc();
    chk("redir_cap_pc", a_ipc, 32'h40);
    chk("redir_cap_valid", 32'(a_valid), 32'h1);
    rv = 1'b1; rpc = 32'h8;
    cyc();
    rv = 1'b0; flush = 1'b1;
    cyc();
    chk("flush_valid", 32'(a_valid), 32'h0);
    chk("flush_addr", a_addr, 32'd12);
    chk("flush_captured_pc", a_ipc, 32'h8);
    flush = 1'b0;
    cyc();
    chk("after_flush_valid", 32'(a_valid), 32'h1);
    chk("after_flush_pc", a_ipc, 32'd12);
    rv = 1'b1; rpc = 32'h42;
    cyc();
    rv = 1'b0;
    chk("mis_fault", 32'(a_fault), 32'h1);
    chk("mis_fault_pc", a_fpc, 32'h42);
    chk("mis_addr", a_addr, 32'd16);
    for (int i = 0; i < 5; i++) begin
      stall = 1'($urandom); flush = 1'($urandom); rv = 1'($urandom); rpc = {$urandom_range(0, 255), 2'b00};
      cyc();
      chk("halt_valid", 32'(a_valid), 32'h0);
      chk("halt_addr", a_addr, 32'd16);
    end
    stall = 1'b0; flush = 1'b0; rv = 1'b0;
    rst = 1'b1;
    cyc();
    chk("rerst_addr", a_addr, 32'h0);
    chk("rerst_fault", 32'(a_fault), 32'h0);
    chk("rerst_fault_pc", a_fpc, 32'h0);
    rst = 1'b0;

    // Randomized run, checked every cycle by the compare process.
    for (int i = 0; i < 800; i++) begin
      int k;
      rst   = ($urandom_range(0, 99) < 3);
      stall = ($urandom_range(0, 99) < 25);
      flush = ($urandom_range(0, 99) < 15);
      rv    = ($urandom_range(0, 99) < 12);
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2, 3, 4: rpc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        5, 6:          rpc = {28'h0, 2'($urandom_range(0, 3)), 2'b00};
        7:             rpc = ($urandom_range(0, 1) != 0) ? 32'd1020 : 32'd1024;
        8:             rpc = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        default:       rpc = 32'hFFFF_FFFC;
      endcase
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
